uart_cmd_sequencer: RTL and testbench

Host-side command issuer for the UART SoC-control channel. It accepts 3-bit control requests and serialises each as one command byte (0x00–0x07) through an external `uart_tool_tx`: clock off/on, reset assert/release, TX route to SoC/controller, RX enable/disable. It models the far-end controller's duplicate-byte suppression and TX routing, and checks command echoes received through an external `uart_tool_rx`. It sits in the CI driver fabric between the test sequencer and the UART pins facing the board under test.

---
 rtl/uart_cmd_sequencer.sv | 179 +++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: turns 3-bit SoC-control requests into single command
// bytes for an external UART transmitter. It mirrors the far-end controller's
// duplicate-byte suppression (last_byte) and TX routing (route_ctrl), and
// checks command echoes when the controller route is selected.
module uart_cmd_sequencer #(
   parameter bit         ECHO_EN      = 1'b1,
   parameter int         ECHO_TIMEOUT = 65536,
   parameter int         GAP_CYCLES   = 64,
   parameter logic [7:0] FILL_BYTE    = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_code,
   output logic       done,
   output logic [1:0] status,
   output logic       busy,
   output logic       uart_tx_en,
   output logic [7:0] uart_tx_data,
   input  logic       uart_tx_busy,
   input  logic       uart_rx_valid,
   input  logic [7:0] uart_rx_data,
   output logic       route_ctrl,
   output logic [7:0] last_byte
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_TX_START, S_TX_DRAIN, S_ECHO, S_GAP, S_DONE
   } state_t;

   state_t      state_q;
   logic [2:0]  cmd_q;
   logic        fill_q;
   logic        route_q;
   logic [7:0]  last_byte_q;
   logic [7:0]  tx_data_q;
   logic        done_q;
   logic [1:0]  status_q;
   logic        echo_exp_q;
   logic        armed_q;
   logic        got_q;
   logic [7:0]  rx_byte_q;
   logic [31:0] cnt_q;

   logic [7:0]  send_byte_d;
   logic        strobe_d;
   logic        route_d;
   logic        echo_exp_d;
   logic        rx_take_d;
   logic        byte_end_d;

   // Byte selection, strobe, routing model and echo capture qualification.
   // The strobe is combinational so a request can reach the TX module in the
   // cycle right after acceptance.
   always_comb begin
      send_byte_d = fill_q ? FILL_BYTE : {5'b0, cmd_q};
      strobe_d    = (state_q == S_SEND) && !uart_tx_busy;
      route_d     = route_q;
      if (send_byte_d == 8'h04) route_d = 1'b0;
      if (send_byte_d == 8'h05) route_d = 1'b1;
      echo_exp_d  = ECHO_EN && route_d;
      // In the strobe cycle capture is freshly armed, so a stale capture from
      // the previous byte must not block it.
      rx_take_d   = uart_rx_valid &&
                    (strobe_d ? echo_exp_d : (armed_q && echo_exp_q && !got_q));
      byte_end_d  = 1'b0;
      case (state_q)
         S_TX_DRAIN: byte_end_d = !uart_tx_busy && !echo_exp_q && (GAP_CYCLES == 0);
         S_ECHO:     byte_end_d = got_q && (rx_byte_q == tx_data_q) && (GAP_CYCLES == 0);
         S_GAP:      byte_end_d = (cnt_q == 32'(GAP_CYCLES - 1));
         default:    byte_end_d = 1'b0;
      endcase
   end

   assign cmd_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign uart_tx_en   = strobe_d;
   assign uart_tx_data = strobe_d ? send_byte_d : tx_data_q;
   assign done         = done_q;
   assign status       = status_q;
   assign route_ctrl   = route_q;
   assign last_byte    = last_byte_q;

   // Sequencer FSM with registered status/done and the controller model.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cmd_q       <= 3'd0;
         fill_q      <= 1'b0;
         route_q     <= 1'b0;
         last_byte_q <= 8'hFF;
         tx_data_q   <= 8'h00;
         done_q      <= 1'b0;
         status_q    <= 2'b00;
         echo_exp_q  <= 1'b0;
         armed_q     <= 1'b0;
         got_q       <= 1'b0;
         rx_byte_q   <= 8'h00;
         cnt_q       <= 32'd0;
      end else begin
         done_q <= 1'b0;
         if (rx_take_d) begin
            got_q     <= 1'b1;
            rx_byte_q <= uart_rx_data;
         end
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  cmd_q   <= cmd_code;
                  fill_q  <= ({5'b0, cmd_code} == last_byte_q);
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               if (!uart_tx_busy) begin
                  tx_data_q   <= send_byte_d;
                  last_byte_q <= send_byte_d;
                  route_q     <= route_d;
                  echo_exp_q  <= echo_exp_d;
                  armed_q     <= 1'b1;
                  got_q       <= rx_take_d;
                  state_q     <= S_TX_START;
               end
            end
            S_TX_START: begin
               if (uart_tx_busy) state_q <= S_TX_DRAIN;
            end
            S_TX_DRAIN: begin
               if (!uart_tx_busy) begin
                  cnt_q   <= 32'd0;
                  state_q <= echo_exp_q ? S_ECHO : S_GAP;
               end
            end
            S_ECHO: begin
               if (got_q) begin
                  armed_q <= 1'b0;
                  if (rx_byte_q == tx_data_q) begin
                     cnt_q   <= 32'd0;
                     state_q <= S_GAP;
                  end else begin
                     status_q <= 2'b10;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end
               end else if (cnt_q == 32'(ECHO_TIMEOUT)) begin
                  armed_q  <= 1'b0;
                  status_q <= 2'b01;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            S_GAP: begin
               cnt_q <= cnt_q + 32'd1;
            end
            S_DONE: begin
               armed_q <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         // End of a byte (after the gap): either the command follows the
         // filler, or the request completes successfully.
         if (byte_end_d) begin
            if (fill_q) begin
               fill_q  <= 1'b0;
               state_q <= S_SEND;
            end else begin
               status_q <= 2'b00;
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a behavioural TX/RX UART model.
module tb_uart_cmd_sequencer;

   localparam int GAP = 4;
   localparam int TMO = 100;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_code;
   logic       done;
   logic [1:0] status;
   logic       busy;
   logic       uart_tx_en;
   logic [7:0] uart_tx_data;
   logic       uart_tx_busy;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;
   logic       route_ctrl;
   logic [7:0] last_byte;

   uart_cmd_sequencer #(
      .ECHO_EN(1'b1), .ECHO_TIMEOUT(TMO), .GAP_CYCLES(GAP), .FILL_BYTE(8'hFF)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_code(cmd_code), .done(done), .status(status), .busy(busy),
      .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
      .uart_tx_busy(uart_tx_busy), .uart_rx_valid(uart_rx_valid),
      .uart_rx_data(uart_rx_data), .route_ctrl(route_ctrl), .last_byte(last_byte)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk = 0;
   int n_fail = 0;

   // UART model state and logs
   int         echo_mode = 0;   // 0 none, 1 reflect sent byte, 2 fixed echo_val
   logic [7:0] echo_val = 8'h00;
   logic [7:0] last_sent = 8'h00;
   int         hold = 0;
   bit         pending = 1'b0;
   int         n_str = 0, n_fall = 0, n_done = 0;
   int         str_cyc [64];
   logic [7:0] str_dat [64];
   int         fall_cyc [64];

   // TX model: busy rises one cycle after a strobe and lasts 20 cycles; an
   // echo (if enabled) arrives as busy falls.
   initial begin
      uart_tx_busy  = 1'b0;
      uart_rx_valid = 1'b0;
      uart_rx_data  = 8'h00;
      forever begin
         @(negedge clk);
         uart_rx_valid = 1'b0;
         if (pending) begin
            pending = 1'b0;
            uart_tx_busy = 1'b1;
            hold = 20;
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) begin
               uart_tx_busy = 1'b0;
               if (n_fall < 64) fall_cyc[n_fall] = cyc;
               n_fall++;
               if (echo_mode == 1) begin
                  uart_rx_valid = 1'b1; uart_rx_data = last_sent;
               end else if (echo_mode == 2) begin
                  uart_rx_valid = 1'b1; uart_rx_data = echo_val;
               end
            end
         end
         #1;
         if (uart_tx_en) begin
            if (n_str < 64) begin
               str_cyc[n_str] = cyc;
               str_dat[n_str] = uart_tx_data;
            end
            n_str++;
            last_sent = uart_tx_data;
            pending = 1'b1;
         end
         if (done) n_done++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic issue(input logic [2:0] code, output int acc);
      step();
      cmd_valid = 1'b1;
      cmd_code  = code;
      acc = cyc;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < maxc; i++) begin
         step();
         if (done === 1'b1) begin
            dcyc = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
      n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL rst_status: got %b want 00", status); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_chk++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_tx_en: got %b want 0", uart_tx_en); end
      n_chk++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", uart_tx_data); end
      n_chk++; if (route_ctrl !== 1'b0) begin n_fail++; $display("FAIL rst_route: got %b want 0", route_ctrl); end
      n_chk++; if (last_byte !== 8'hFF) begin n_fail++; $display("FAIL rst_last_byte: got %h want ff", last_byte); end
   endtask

   task automatic test_single();
      int s0, f0, acc, dc;
      s0 = n_str; f0 = n_fall;
      issue(3'd1, acc);
      wait_done(200, dc);
      n_chk++; if (dc == -1) begin n_fail++; $display("FAIL single_done: got none want pulse within 200"); end
      n_chk++; if (n_str - s0 !== 1) begin n_fail++; $display("FAIL single_strobes: got %0d want 1", n_str - s0); end
      n_chk++; if (str_dat[s0] !== 8'h01) begin n_fail++; $display("FAIL single_data: got %h want 01", str_dat[s0]); end
      n_chk++; if (str_cyc[s0] !== acc + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", str_cyc[s0], acc + 1); end
      n_chk++; if (dc !== fall_cyc[f0] + GAP + 1) begin n_fail++; $display("FAIL single_done_time: got %0d want %0d", dc, fall_cyc[f0] + GAP + 1); end
      n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL single_status: got %b want 00", status); end
      n_chk++; if (last_byte !== 8'h01) begin n_fail++; $display("FAIL single_last_byte: got %h want 01", last_byte); end
      step();
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", done); end
   endtask

   task automatic test_filler();
      int s0, f0, d0, acc, dc;
      s0 = n_str; f0 = n_fall; d0 = n_done;
      issue(3'd1, acc);
      wait_done(300, dc);
      repeat (10) step();
      n_chk++; if (n_str - s0 !== 2) begin n_fail++; $display("FAIL fill_strobes: got %0d want 2", n_str - s0); end
      n_chk++; if (str_dat[s0] !== 8'hFF) begin n_fail++; $display("FAIL fill_first: got %h want ff", str_dat[s0]); end
      n_chk++; if (str_dat[s0 + 1] !== 8'h01) begin n_fail++; $display("FAIL fill_second: got %h want 01", str_dat[s0 + 1]); end
      n_chk++; if (str_cyc[s0 + 1] !== fall_cyc[f0] + GAP + 1) begin n_fail++; $display("FAIL fill_gap: got %0d want %0d", str_cyc[s0 + 1], fall_cyc[f0] + GAP + 1); end
      n_chk++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL fill_done_count: got %0d want 1", n_done - d0); end
      n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL fill_status: got %b want 00", status); end
   endtask

   task automatic test_echo();
      int s0, f0, acc, dc;
      echo_mode = 1;
      f0 = n_fall;
      issue(3'd5, acc);
      wait_done(300, dc);
      n_chk++; if (dc !== fall_cyc[f0] + GAP + 2) begin n_fail++; $display("FAIL echo5_done_time: got %0d want %0d", dc, fall_cyc[f0] + GAP + 2); end
      n_chk++; if (route_ctrl !== 1'b1) begin n_fail++; $display("FAIL echo5_route: got %b want 1", route_ctrl); end
      n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL echo5_status: got %b want 00", status); end
      s0 = n_str;
      issue(3'd2, acc);
      wait_done(300, dc);
      n_chk++; if (dc == -1) begin n_fail++; $display("FAIL echo2_done: got none want pulse"); end
      n_chk++; if (n_str - s0 !== 1) begin n_fail++; $display("FAIL echo2_strobes: got %0d want 1", n_str - s0); end
      n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL echo2_status: got %b want 00", status); end
      n_chk++; if (last_byte !== 8'h02) begin n_fail++; $display("FAIL echo2_last_byte: got %h want 02", last_byte); end
   endtask

   task automatic test_timeout();
      int f0, acc, dc;
      echo_mode = 0;
      f0 = n_fall;
      issue(3'd3, acc);
      wait_done(400, dc);
      n_chk++; if (dc !== fall_cyc[f0] + 1 + TMO + 1) begin n_fail++; $display("FAIL tmo_done_time: got %0d want %0d", dc, fall_cyc[f0] + TMO + 2); end
      n_chk++; if (status !== 2'b01) begin n_fail++; $display("FAIL tmo_status: got %b want 01", status); end
      n_chk++; if (last_byte !== 8'h03) begin n_fail++; $display("FAIL tmo_last_byte: got %h want 03", last_byte); end
   endtask

   task automatic test_mismatch();
      int f0, d0, acc, dc;
      echo_mode = 2; echo_val = 8'h13;
      f0 = n_fall;
      issue(3'd6, acc);
      wait_done(300, dc);
      n_chk++; if (dc !== fall_cyc[f0] + 2) begin n_fail++; $display("FAIL mis_done_time: got %0d want %0d", dc, fall_cyc[f0] + 2); end
      n_chk++; if (status !== 2'b10) begin n_fail++; $display("FAIL mis_status: got %b want 10", status); end
      n_chk++; if (last_byte !== 8'h06) begin n_fail++; $display("FAIL mis_last_byte: got %h want 06", last_byte); end
      f0 = n_fall;
      issue(3'd4, acc);
      wait_done(300, dc);
      n_chk++; if (dc !== fall_cyc[f0] + GAP + 1) begin n_fail++; $display("FAIL cmd4_done_time: got %0d want %0d", dc, fall_cyc[f0] + GAP + 1); end
      n_chk++; if (route_ctrl !== 1'b0) begin n_fail++; $display("FAIL cmd4_route: got %b want 0", route_ctrl); end
      n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL cmd4_status: got %b want 00", status); end
      echo_mode = 0;
      step();
      d0 = n_done;
      uart_rx_valid = 1'b1; uart_rx_data = 8'h04;
      repeat (6) step();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx_ignored_busy: got %b want 0", busy); end
      n_chk++; if (n_done !== d0) begin n_fail++; $display("FAIL rx_ignored_done: got %0d want %0d", n_done, d0); end
   endtask

   task automatic test_reset_mid();
      int s0, fi, acc, dc;
      issue(3'd7, acc);
      repeat (8) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
      n_chk++; if (last_byte !== 8'hFF) begin n_fail++; $display("FAIL mid_last_byte: got %h want ff", last_byte); end
      n_chk++; if (route_ctrl !== 1'b0) begin n_fail++; $display("FAIL mid_route: got %b want 0", route_ctrl); end
      n_chk++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: got %h want 00", uart_tx_data); end
      n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL mid_status: got %b want 00", status); end
      fi = n_fall; s0 = n_str;
      issue(3'd0, acc);
      wait_done(300, dc);
      n_chk++; if (n_str - s0 !== 1) begin n_fail++; $display("FAIL mid_strobes: got %0d want 1", n_str - s0); end
      n_chk++; if (str_dat[s0] !== 8'h00) begin n_fail++; $display("FAIL mid_data: got %h want 00", str_dat[s0]); end
      n_chk++; if (str_cyc[s0] !== fall_cyc[fi]) begin n_fail++; $display("FAIL mid_withheld: got %0d want %0d", str_cyc[s0], fall_cyc[fi]); end
      n_chk++; if (status !== 2'b00) begin n_fail++; $display("FAIL mid_done_status: got %b want 00", status); end
      n_chk++; if (last_byte !== 8'h00) begin n_fail++; $display("FAIL mid_done_last: got %h want 00", last_byte); end
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_code = 3'd0;
      repeat (3) step();
      reset = 1'b0;
      step();
      test_reset();
      test_single();
      test_filler();
      test_echo();
      test_timeout();
      test_mismatch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
